lt24_frame_reader: RTL and testbench

- Avalon-MM read master that fetches a contiguous range of 32-bit words from the on-chip memory slave (fixed read latency 1, no waitrequest).
- Unpacks each word into two RGB565 pixels and presents them on a ready/valid pixel stream to the LT24 LCD controller.
- Buffers fetched words in a small FIFO so LCD back-pressure never loses read data.

---
 rtl/lt24_pkg.sv | 15 +
 rtl/lt24_word_fifo.sv | 54 +++++
 rtl/lt24_frame_reader.sv | 156 +++++++++++++++
 tb/tb_lt24_frame_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lt24_pkg.sv
// Shared types and constants for the LT24 frame reader: FSM states and pixel/word geometry.
package lt24_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int PIX_W        = 16;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_WORD = 2;

endpackage

// File: rtl/lt24_word_fifo.sv
// Synchronous word FIFO with occupancy count; head word is visible combinationally on pop_data.
module lt24_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & ~full;
    // DEPTH is a power of two, so pointers wrap naturally.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    pop_data = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/lt24_frame_reader.sv
// Avalon-MM read master that streams a word range from on-chip memory as RGB565 pixels,
// low half of each word first, with a word FIFO absorbing LCD back-pressure.
module lt24_frame_reader
  import lt24_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  output logic [15:0]       px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              px_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W:0]     total_q, total_d;
  logic [ADDR_W:0]     word_idx_q, word_idx_d;
  logic                half_q, half_d;
  logic                cs_q, cs_d;
  logic                cap_q, cap_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty, fifo_full, fifo_pop, accept;
  logic [WORD_W-1:0]   head;
  logic [CNT_W:0]      credit_used;

  lt24_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cap_q),
    .push_data (avm_readdata),
    .pop       (fifo_pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    accept   = ~fifo_empty & px_ready;
    fifo_pop = accept & half_q;
    px_valid = ~fifo_empty;
    px_data  = half_q ? head[WORD_W-1:PIX_W] : head[PIX_W-1:0];
    px_last  = ~fifo_empty & half_q & (word_idx_q == total_q);
    // Words already committed: stored, landing this cycle, and the read on the bus now.
    credit_used = {1'b0, fifo_count} + (CNT_W+1)'(cap_q) + (CNT_W+1)'(cs_q);

    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    total_d    = total_q;
    word_idx_d = word_idx_q;
    half_d     = half_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cs_d       = 1'b0;
    cap_d      = cs_q;

    if (accept)   half_d     = ~half_q;
    if (fifo_pop) word_idx_d = word_idx_q + (ADDR_W+1)'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          rem_d      = word_count;
          total_d    = word_count;
          word_idx_d = (ADDR_W+1)'(1);
          half_d     = 1'b0;
          if (word_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_READ;
            busy_d  = 1'b1;
            cs_d    = 1'b1;
          end
        end
      end
      ST_READ: begin
        addr_d = addr_q + ADDR_W'(cs_q);
        rem_d  = rem_q - (ADDR_W+1)'(cs_q);
        if (cs_q && rem_q == (ADDR_W+1)'(1)) begin
          state_d = ST_DRAIN;
        end else begin
          cs_d = ~fifo_full && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
        end
      end
      ST_DRAIN: begin
        if (accept && px_last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      total_q    <= '0;
      word_idx_q <= '0;
      half_q     <= 1'b0;
      cs_q       <= 1'b0;
      cap_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      total_q    <= total_d;
      word_idx_q <= word_idx_d;
      half_q     <= half_d;
      cs_q       <= cs_d;
      cap_q      <= cap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_lt24_frame_reader.sv
// Scoreboard bench for lt24_frame_reader: a memory model, expected read-address and pixel queues
// filled at start time, and a negedge monitor that checks the bus and pixel stream.
module tb_lt24_frame_reader;

  localparam int ADDR_W     = 12;
  localparam int FIFO_DEPTH = 8;
  localparam int MEM_WORDS  = 4096;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect, avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata = '0;
  logic [15:0]       px_data;
  logic              px_valid, px_last;
  logic              px_ready = 1'b0;

  always #5 clk = ~clk;

  lt24_frame_reader #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_byteenable (avm_byteenable),
    .avm_readdata   (avm_readdata),
    .px_data        (px_data),
    .px_valid       (px_valid),
    .px_ready       (px_ready),
    .px_last        (px_last)
  );

  // Memory slave: fixed read latency of one cycle.
  logic [31:0] mem [MEM_WORDS];
  always @(posedge clk) if (avm_chipselect) avm_readdata <= mem[avm_address];

  typedef struct {
    logic [15:0] d;
    logic        last;
  } pix_t;

  pix_t              exp_px[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int checks = 0;
  int fails = 0;
  int cs_total = 0;
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fill_pattern();
    for (int n = 0; n < MEM_WORDS; n++) begin
      logic [15:0] lo, hi;
      lo = 16'(2 * n);
      hi = 16'(2 * n + 1);
      mem[n] = {hi, lo};
    end
  endtask

  // Ready driver: 0 = always ready, 1 = held off, 2 = random 50%.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       px_ready = 1'b1;
      1:       px_ready = 1'b0;
      default: px_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor and reference model.
  logic        busy_m = 1'b0, done_m = 1'b0;
  logic        stall_prev = 1'b0, held_last = 1'b0;
  logic [15:0] held_d = '0;

  always @(negedge clk) begin : monitor
    pix_t e;
    logic acc, last_acc;
    if (!reset_n) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cs", avm_chipselect, 0);
      check("rst_addr", avm_address, 0);
      check("rst_px_valid", px_valid, 0);
      check("rst_px_last", px_last, 0);
      exp_px.delete();
      exp_addr.delete();
      busy_m = 1'b0;
      done_m = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("busy", busy, busy_m);
      check("done", done, done_m);
      check("fifo_bound", 32'(dut.fifo_count <= FIFO_DEPTH), 1);
      if (avm_chipselect) begin
        cs_total++;
        check("rd_write", avm_write, 0);
        check("rd_byteenable", avm_byteenable, 4'hF);
        if (exp_addr.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_addr", avm_address, exp_addr.pop_front());
      end
      if (stall_prev) begin
        check("stall_valid", px_valid, 1);
        check("stall_data", px_data, held_d);
        check("stall_last", px_last, held_last);
      end
      acc = px_valid & px_ready;
      last_acc = 1'b0;
      if (acc) begin
        if (exp_px.size() == 0) check("px_unexpected", 1, 0);
        else begin
          e = exp_px.pop_front();
          check("px_data", px_data, e.d);
          check("px_last", px_last, e.last);
          last_acc = e.last;
        end
      end
      done_m = last_acc || (start && word_count == '0);
      if (start && word_count != '0) busy_m = 1'b1;
      else if (last_acc) busy_m = 1'b0;
      stall_prev = px_valid & ~px_ready;
      held_d = px_data;
      held_last = px_last;
    end
  end

  task automatic start_xfer(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int a;
      logic [31:0] w;
      a = (base + i) % MEM_WORDS;
      w = mem[a];
      exp_addr.push_back(ADDR_W'(a));
      exp_px.push_back('{d: w[15:0], last: 1'b0});
      exp_px.push_back('{d: w[31:16], last: (i == cnt - 1)});
    end
    @(posedge clk);
    #1;
    base_addr  = ADDR_W'(base);
    word_count = (ADDR_W+1)'(cnt);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check({name, "_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic end_xfer(input string name, input int cs0, input int reads);
    check({name, "_reads"}, cs_total - cs0, reads);
    check({name, "_px_left"}, exp_px.size(), 0);
    check({name, "_addr_left"}, exp_addr.size(), 0);
  endtask

  initial begin
    int cs0, n;
    fill_pattern();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Sequential 16-word frame, always ready.
    ready_mode = 0;
    cs0 = cs_total;
    start_xfer(0, 16);
    wait_done("seq", 500);
    end_xfer("seq", cs0, 16);

    // Address wrap at the top of memory.
    cs0 = cs_total;
    start_xfer(12'hFFE, 4);
    wait_done("wrap", 500);
    end_xfer("wrap", cs0, 4);

    // Empty transfer.
    cs0 = cs_total;
    start_xfer(0, 0);
    wait_done("zero", 50);
    end_xfer("zero", cs0, 0);

    // Consumer stalled for 40 cycles: reads stop once the FIFO is committed.
    ready_mode = 1;
    cs0 = cs_total;
    start_xfer(0, 16);
    repeat (40) @(negedge clk);
    check("stall_reads", cs_total - cs0, FIFO_DEPTH);
    ready_mode = 0;
    wait_done("stall", 500);
    end_xfer("stall", cs0, 16);

    // Random data, random base, random back-pressure.
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    ready_mode = 2;
    cs0 = cs_total;
    start_xfer(int'($urandom_range(0, MEM_WORDS - 1)), 64);
    wait_done("rand", 3000);
    end_xfer("rand", cs0, 64);

    // Reset in the middle of a transfer, then a fresh short transfer.
    fill_pattern();
    ready_mode = 0;
    cs0 = cs_total;
    start_xfer(0, 16);
    n = 0;
    while (cs_total - cs0 < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("abort_wait_timeout", 1, 0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    cs0 = cs_total;
    start_xfer(12'h100, 2);
    wait_done("after_rst", 200);
    end_xfer("after_rst", cs0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
